// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem req/gnt/rvalid reads, in-order buffer to decode.
// Latency rvalid -> instr_valid one cycle; requests stop when buffered+outstanding words fill FIFO_DEPTH.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic          run;

    logic [CW:0]   credit_used;
    logic          req_gnt_vld;
    logic          rsp_vld;
    logic          push_vld;
    logic          pop_vld;
    logic [CW-1:0] outstanding_nxt;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outstanding words count against the buffer even if they will be dropped.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign imem_req    = run && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc;

    assign req_gnt_vld     = imem_req && imem_gnt;
    assign rsp_vld         = imem_rvalid && (outstanding != '0);
    assign push_vld        = rsp_vld && (drop_cnt == '0) && !redirect_valid;
    assign pop_vld         = instr_valid && instr_ready && !redirect_valid;
    assign outstanding_nxt = outstanding + CW'(req_gnt_vld) - CW'(rsp_vld);

    assign instr_valid = (fifo_cnt != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                drop_cnt <= outstanding_nxt;
                fifo_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_gnt_vld) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_vld && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push_vld) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= resp_pc;
                    wr_ptr             <= wr_ptr + 1'b1;
                    resp_pc            <= resp_pc + 32'd4;
                end
                if (pop_vld) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_cnt <= fifo_cnt + CW'(push_vld) - CW'(pop_vld);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences, randomized run against a queue model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RESET_PC = 0
    logic        a_rst_n, a_req, a_gnt, a_rvalid, a_redir, a_vld, a_rdy;
    logic [31:0] a_addr, a_rdata, a_rpc, a_instr, a_pc;
    // Instance B: RESET_PC near the top of the address space
    logic        b_rst_n, b_req, b_gnt, b_rvalid, b_redir, b_vld, b_rdy;
    logic [31:0] b_addr, b_rdata, b_rpc, b_instr, b_pc;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(a_rst_n), .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(a_gnt),
        .imem_rvalid(a_rvalid), .imem_rdata(a_rdata), .redirect_valid(a_redir), .redirect_pc(a_rpc),
        .instr_valid(a_vld), .instr_ready(a_rdy), .instr(a_instr), .instr_pc(a_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(b_rst_n), .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
        .imem_rvalid(b_rvalid), .imem_rdata(b_rdata), .redirect_valid(b_redir), .redirect_pc(b_rpc),
        .instr_valid(b_vld), .instr_ready(b_rdy), .instr(b_instr), .instr_pc(b_pc)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] ra, input logic rdy,
                                input logic rd, input logic [31:0] rpc, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] epc);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rv ? memword(ra) : 32'h0;
        v.ready = rdy; v.redir = rd; v.rpc = rpc;
        v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = epc;
        return v;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        live;
    } fl_t;

    fl_t         infl[$];
    logic [31:0] fq_pc[$];
    logic [31:0] fq_dat[$];
    logic [31:0] nf;
    vec_t        tbl[20];

    task automatic reset_a();
        a_rst_n = 1'b0; a_gnt = 0; a_rvalid = 0; a_rdata = 0; a_redir = 0; a_rpc = 0; a_rdy = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst req",   32'(a_req), 32'd0);
        check("rst addr",  a_addr,     32'h0);
        check("rst vld",   32'(a_vld), 32'd0);
        check("rst instr", a_instr,    32'h0);
        check("rst pc",    a_pc,       32'h0);
        @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    initial begin
        logic        exp_req, rd, rv, rdy, g;
        logic [31:0] rpc, rdat;
        int          lvl;
        fl_t         e;

        b_rst_n = 1'b0; b_gnt = 0; b_rvalid = 0; b_rdata = 0; b_redir = 0; b_rpc = 0; b_rdy = 0;

        //            gnt rv resp-addr    rdy red rpc           req addr          vld pc
        tbl[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h000, 0, 32'h0);
        tbl[1]  = mk(1, 1, 32'h0,   0, 0, 32'h0,   1, 32'h004, 0, 32'h0);
        tbl[2]  = mk(0, 1, 32'h4,   0, 0, 32'h0,   0, 32'h008, 1, 32'h0);
        tbl[3]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h008, 1, 32'h0);
        tbl[4]  = mk(0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h008, 1, 32'h0);
        tbl[5]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h008, 1, 32'h4);
        tbl[6]  = mk(1, 1, 32'h8,   1, 0, 32'h0,   1, 32'h00C, 0, 32'h0);
        tbl[7]  = mk(0, 1, 32'hC,   1, 0, 32'h0,   0, 32'h010, 1, 32'h8);
        tbl[8]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h010, 1, 32'hC);
        tbl[9]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h014, 0, 32'h0);
        tbl[10] = mk(0, 1, 32'h10,  1, 1, 32'h103, 0, 32'h018, 0, 32'h0);
        tbl[11] = mk(1, 1, 32'h14,  1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        tbl[12] = mk(0, 1, 32'h100, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        tbl[13] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
        tbl[14] = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h104, 1, 32'h100);
        tbl[15] = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        tbl[16] = mk(0, 1, 32'h200, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        tbl[17] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h204, 1, 32'h200);
        tbl[18] = mk(0, 1, 32'h204, 1, 1, 32'h300, 0, 32'h208, 1, 32'h200);
        tbl[19] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h300, 0, 32'h0);

        reset_a();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_gnt = tbl[i].gnt; a_rvalid = tbl[i].rvalid; a_rdata = tbl[i].rdata;
            a_rdy = tbl[i].ready; a_redir = tbl[i].redir; a_rpc = tbl[i].rpc;
            #1;
            check($sformatf("t%0d req", i),  32'(a_req), 32'(tbl[i].e_req));
            check($sformatf("t%0d addr", i), a_addr,     tbl[i].e_addr);
            check($sformatf("t%0d vld", i),  32'(a_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                check($sformatf("t%0d pc", i),    a_pc,    tbl[i].e_pc);
                check($sformatf("t%0d instr", i), a_instr, memword(tbl[i].e_pc));
            end
        end

        // Wrap-around fetch and asynchronous reset in the middle of a burst
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        @(negedge clk);
        b_gnt = 1; b_rdy = 1; #1;
        check("wrap req0",  32'(b_req), 32'd1);
        check("wrap addr0", b_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        b_rvalid = 1; b_rdata = memword(32'hFFFF_FFF8); #1;
        check("wrap req1",  32'(b_req), 32'd1);
        check("wrap addr1", b_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        b_rdata = memword(32'hFFFF_FFFC); #1;
        check("wrap req2",  32'(b_req), 32'd0);
        check("wrap addr2", b_addr, 32'h0000_0000);
        check("wrap pc2",   b_pc,   32'hFFFF_FFF8);
        @(negedge clk);
        b_rvalid = 0; #1;
        check("wrap req3",   32'(b_req), 32'd1);
        check("wrap addr3",  b_addr,  32'h0000_0000);
        check("wrap vld3",   32'(b_vld), 32'd1);
        check("wrap pc3",    b_pc,    32'hFFFF_FFFC);
        check("wrap instr3", b_instr, memword(32'hFFFF_FFFC));
        b_rst_n = 1'b0; #1;
        check("midrst req",   32'(b_req), 32'd0);
        check("midrst vld",   32'(b_vld), 32'd0);
        check("midrst addr",  b_addr,  32'hFFFF_FFF8);
        check("midrst instr", b_instr, 32'h0);
        b_gnt = 0; b_rdy = 0;

        // Randomized run against the queue model
        reset_a();
        nf = 32'h0;
        infl.delete(); fq_pc.delete(); fq_dat.delete();
        for (int c = 0; c < 4000; c++) begin
            lvl = (c / 500) % 4 + 1;
            @(negedge clk);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = {28'hFFFF_FFF, rpc[3:0]};
            rdy = ($urandom_range(0, 3) < lvl);
            rv  = (infl.size() > 0) && ($urandom_range(0, 1) == 1);
            rdat = rv ? memword(infl[0].addr) : $urandom();
            a_redir = rd; a_rpc = rpc; a_rdy = rdy; a_rvalid = rv; a_rdata = rdat; a_gnt = 0;
            #1;
            exp_req = !rd && ((fq_pc.size() + infl.size()) < 2);
            check("rnd req",  32'(a_req), 32'(exp_req));
            check("rnd addr", a_addr, nf);
            check("rnd vld",  32'(a_vld), 32'(fq_pc.size() > 0));
            if (fq_pc.size() > 0) begin
                check("rnd pc",    a_pc,    fq_pc[0]);
                check("rnd instr", a_instr, fq_dat[0]);
            end
            g = a_req && ($urandom_range(0, 2) != 0);
            a_gnt = g;
            if (fq_pc.size() > 0 && rdy && !rd) begin
                void'(fq_pc.pop_front());
                void'(fq_dat.pop_front());
            end
            if (rv) begin
                e = infl.pop_front();
                if (e.live && !rd) begin
                    fq_pc.push_back(e.addr);
                    fq_dat.push_back(rdat);
                end
            end
            if (a_req && g) begin
                e.addr = nf; e.live = 1'b1;
                infl.push_back(e);
                nf = nf + 32'd4;
            end
            if (rd) begin
                fq_pc.delete(); fq_dat.delete();
                foreach (infl[k]) infl[k].live = 1'b0;
                nf = {rpc[31:2], 2'b00};
            end
        end

        @(negedge clk);
        a_gnt = 0; a_rvalid = 0; a_redir = 0; a_rdy = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
